// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller and its MDU sequencer.
package hazard_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $0 is hardwired to zero, so a write to it can never create a dependency.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/EX observation inputs and pipeline control outputs of the hazard controller.
interface hazard_ctrl_if #(
  parameter int PERF_W = 32
);
  // No valid/ready handshake: every input is sampled each cycle and every control
  // output is a same-cycle combinational answer. mdu_start_o and mdu_done_o are
  // single-cycle pulses that the MDU datapath must act on in the cycle they are high.
  logic [4:0]        id_rs_addr_i;
  logic [4:0]        id_rt_addr_i;
  logic              id_uses_rt_i;
  logic              id_br_taken_i;
  logic              id_mdu_start_i;
  logic              id_mdu_use_i;
  logic              ex_memread_i;
  logic [4:0]        ex_rt_addr_i;
  logic              pc_write_o;
  logic              ifid_write_o;
  logic              ifid_flush_o;
  logic              idex_bubble_o;
  logic              mdu_start_o;
  logic              mdu_busy_o;
  logic              mdu_done_o;
  logic [PERF_W-1:0] stall_cnt_o;

  modport master (
    output id_rs_addr_i, id_rt_addr_i, id_uses_rt_i, id_br_taken_i,
           id_mdu_start_i, id_mdu_use_i, ex_memread_i, ex_rt_addr_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           mdu_start_o, mdu_busy_o, mdu_done_o, stall_cnt_o
  );

  modport slave (
    input  id_rs_addr_i, id_rt_addr_i, id_uses_rt_i, id_br_taken_i,
           id_mdu_start_i, id_mdu_use_i, ex_memread_i, ex_rt_addr_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           mdu_start_o, mdu_busy_o, mdu_done_o, stall_cnt_o
  );

endinterface

// File: rtl/hazard_ctrl_mdu_seq.sv
// IDLE/BUSY sequencer with countdown that tracks the multi-cycle multiply/divide unit.
module mdu_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic       start_o,
  output logic       done_o,
  output mdu_state_e state_o
);

  localparam int CNT_W = (MDU_CYCLES > 1) ? $clog2(MDU_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CYCLES - 1);

  mdu_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Outputs are masked while reset is high so an op aborted by reset never pulses done.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    start_o = 1'b0;
    done_o  = 1'b0;
    busy_o  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i && !rst_i) begin
          state_n = ST_BUSY;
          cnt_n   = CNT_LOAD;
          start_o = 1'b1;
        end
      end
      ST_BUSY: begin
        busy_o = !rst_i;
        if (cnt == '0) begin
          done_o  = !rst_i;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign state_o = state;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / MDU stall, branch flush and stall-cycle counting for the 5-stage pipeline.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES = 32,
  parameter int PERF_W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave hz
);

  logic              lu_haz;
  logic              mdu_haz;
  logic              stall;
  logic              mdu_req;
  mdu_state_e        mdu_state;
  logic [PERF_W-1:0] stall_cnt;

  assign lu_haz = hz.ex_memread_i &
                  (reg_match(hz.ex_rt_addr_i, hz.id_rs_addr_i) |
                   (hz.id_uses_rt_i & reg_match(hz.ex_rt_addr_i, hz.id_rt_addr_i)));

  assign mdu_haz = (mdu_state != ST_IDLE) & (hz.id_mdu_start_i | hz.id_mdu_use_i);
  assign stall   = lu_haz | mdu_haz;

  // A mult/div stuck behind a load must not launch until its operands are real.
  assign mdu_req = hz.id_mdu_start_i & ~lu_haz;

  mdu_seq #(
    .MDU_CYCLES(MDU_CYCLES)
  ) u_mdu_seq (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(mdu_req),
    .busy_o (hz.mdu_busy_o),
    .start_o(hz.mdu_start_o),
    .done_o (hz.mdu_done_o),
    .state_o(mdu_state)
  );

  always_comb begin
    hz.pc_write_o    = 1'b0;
    hz.ifid_write_o  = 1'b0;
    hz.ifid_flush_o  = 1'b0;
    hz.idex_bubble_o = 1'b1;
    if (!rst_i) begin
      hz.pc_write_o    = ~stall;
      hz.ifid_write_o  = ~stall;
      hz.idex_bubble_o = stall;
      // A stalled branch is re-evaluated next cycle, so it must not flush yet.
      hz.ifid_flush_o  = hz.id_br_taken_i & ~stall;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

  assign hz.stall_cnt_o = rst_i ? '0 : stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed check of hazard_ctrl: load-use, rt masking, branch priority, MDU timing,
// counter saturation (PERF_W=3) and reset abort.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int MDU_CYCLES = 4;
  localparam int PERF_W     = 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hazard_ctrl_if #(.PERF_W(PERF_W)) hz ();

  hazard_ctrl #(
    .MDU_CYCLES(MDU_CYCLES),
    .PERF_W    (PERF_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .hz   (hz)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: apply one cycle of inputs, check mid-cycle, advance to just after the edge.
  // ctrl = {pc_write, ifid_write, ifid_flush, idex_bubble}; mdu = {start, busy, done}
  task automatic cyc(input string tag, input logic r,
                     input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                     input logic br, input logic mstart, input logic muse,
                     input logic memread, input logic [4:0] ex_rt,
                     input logic [3:0] ctrl_exp, input logic [2:0] mdu_exp,
                     input logic [PERF_W-1:0] cnt_exp);
    rst                = r;
    hz.id_rs_addr_i    = rs;
    hz.id_rt_addr_i    = rt;
    hz.id_uses_rt_i    = uses_rt;
    hz.id_br_taken_i   = br;
    hz.id_mdu_start_i  = mstart;
    hz.id_mdu_use_i    = muse;
    hz.ex_memread_i    = memread;
    hz.ex_rt_addr_i    = ex_rt;
    #4;
    chk({tag, ".ctrl"}, {4'b0, hz.pc_write_o, hz.ifid_write_o, hz.ifid_flush_o, hz.idex_bubble_o},
        {4'b0, ctrl_exp});
    chk({tag, ".mdu"}, {5'b0, hz.mdu_start_o, hz.mdu_busy_o, hz.mdu_done_o}, {5'b0, mdu_exp});
    chk({tag, ".cnt"}, {5'b0, hz.stall_cnt_o}, {5'b0, cnt_exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    hz.id_rs_addr_i = '0; hz.id_rt_addr_i = '0; hz.id_uses_rt_i = 1'b0;
    hz.id_br_taken_i = 1'b0; hz.id_mdu_start_i = 1'b0; hz.id_mdu_use_i = 1'b0;
    hz.ex_memread_i = 1'b0; hz.ex_rt_addr_i = '0;
    @(posedge clk);
    #1;
    //   tag          r  rs  rt  u  br st us mr ex   ctrl     mdu     cnt
    cyc("reset",      1, 0,  0,  0, 0, 1, 0, 0, 0,   4'b0001, 3'b000, 0);
    cyc("idle",       0, 0,  0,  0, 0, 0, 0, 0, 0,   4'b1100, 3'b000, 0);
    cyc("lu_stall",   0, 8,  0,  0, 0, 0, 0, 1, 8,   4'b0001, 3'b000, 0);
    cyc("lu_release", 0, 8,  0,  0, 0, 0, 0, 0, 0,   4'b1100, 3'b000, 1);
    cyc("rt_masked",  0, 3,  8,  0, 0, 0, 0, 1, 8,   4'b1100, 3'b000, 1);
    cyc("rt_used",    0, 3,  8,  1, 0, 0, 0, 1, 8,   4'b0001, 3'b000, 1);
    cyc("load_r0",    0, 0,  0,  1, 0, 0, 0, 1, 0,   4'b1100, 3'b000, 2);
    cyc("br_stall",   0, 5,  0,  0, 1, 0, 0, 1, 5,   4'b0001, 3'b000, 2);
    cyc("br_flush",   0, 5,  0,  0, 1, 0, 0, 0, 0,   4'b1110, 3'b000, 3);
    // MDU op: start at t, mfhi from t+1 stalls through done at t+4
    cyc("mdu_t0",     0, 1,  2,  1, 0, 1, 0, 0, 0,   4'b1100, 3'b100, 3);
    cyc("mfhi_t1",    0, 0,  0,  0, 0, 0, 1, 0, 0,   4'b0001, 3'b010, 3);
    cyc("mfhi_t2",    0, 0,  0,  0, 0, 0, 1, 0, 0,   4'b0001, 3'b010, 4);
    cyc("mfhi_t3",    0, 0,  0,  0, 0, 0, 1, 0, 0,   4'b0001, 3'b010, 5);
    cyc("mfhi_t4",    0, 0,  0,  0, 0, 0, 1, 0, 0,   4'b0001, 3'b011, 6);
    cyc("mfhi_t5",    0, 0,  0,  0, 0, 0, 1, 0, 0,   4'b1100, 3'b000, 7);
    // Start blocked by a load-use hazard; counter already at all-ones stays there
    cyc("mult_lu",    0, 9,  0,  0, 0, 1, 0, 1, 9,   4'b0001, 3'b000, 7);
    // Back-to-back mult with an independent add flowing while busy
    cyc("b2b_t0",     0, 9,  0,  0, 0, 1, 0, 0, 0,   4'b1100, 3'b100, 7);
    cyc("add_t1",     0, 4,  6,  1, 0, 0, 0, 0, 0,   4'b1100, 3'b010, 7);
    cyc("b2b_t2",     0, 1,  2,  1, 0, 1, 0, 0, 0,   4'b0001, 3'b010, 7);
    cyc("b2b_t3",     0, 1,  2,  1, 0, 1, 0, 0, 0,   4'b0001, 3'b010, 7);
    cyc("b2b_t4",     0, 1,  2,  1, 0, 1, 0, 0, 0,   4'b0001, 3'b011, 7);
    cyc("b2b_t5",     0, 1,  2,  1, 0, 1, 0, 0, 0,   4'b1100, 3'b100, 7);
    // Reset two cycles into the second op aborts it without a done pulse
    cyc("abort_t1",   0, 0,  0,  0, 0, 0, 0, 0, 0,   4'b1100, 3'b010, 7);
    cyc("abort_rst",  1, 0,  0,  0, 0, 0, 1, 0, 0,   4'b0001, 3'b000, 0);
    cyc("abort_t3",   0, 0,  0,  0, 0, 0, 0, 0, 0,   4'b1100, 3'b000, 0);
    cyc("abort_t4",   0, 0,  0,  0, 0, 0, 0, 0, 0,   4'b1100, 3'b000, 0);
    cyc("mfhi_idle",  0, 0,  0,  0, 0, 0, 1, 0, 0,   4'b1100, 3'b000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #5000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
